cdb_arbiter: RTL

- Sits directly downstream of the functional units (ALU, branch, load/store) and arbitrates their finished results onto the single common data bus (CDB).
- Each unit presents a result with a destination tag. The arbiter grants one unit per cycle, round-robin.
- The granted result is broadcast, registered, to the reservation stations, register file and reorder buffer.
- A flush input squashes in-flight broadcasts on branch misprediction.

---
 rtl/cdb_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter that merges functional-unit results onto
// the single common data bus. The winning result is broadcast one cycle after
// its transfer. flush_i squashes grants; rst_i (synchronous) overrides flush_i.
// Optional build macro CDB_ARBITER_STATS_EN adds saturating broadcast and
// conflict counters.
module cdb_arbiter #(
  parameter int NumUnits      = 4,
  parameter int DatapathWidth = 2,
  parameter int TagWidth      = 3,
  localparam int IdxW         = $clog2(NumUnits)
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              flush_i,
  input  logic [NumUnits-1:0]               fu_valid_i,
  output logic [NumUnits-1:0]               fu_ready_o,
  input  logic [NumUnits*TagWidth-1:0]      fu_tag_i,
  input  logic [NumUnits*DatapathWidth-1:0] fu_result_i,
  input  logic [NumUnits-1:0]               fu_branch_taken_i,
  output logic                              cdb_valid_o,
  output logic [TagWidth-1:0]               cdb_tag_o,
  output logic [DatapathWidth-1:0]          cdb_result_o,
  output logic                              cdb_branch_taken_o,
  output logic [IdxW-1:0]                   cdb_unit_o
`ifdef CDB_ARBITER_STATS_EN
  ,
  output logic [15:0]                       stat_broadcasts_o,
  output logic [15:0]                       stat_conflicts_o
`endif
);

  logic [IdxW-1:0]          ptr_q, ptr_d;
  logic [NumUnits-1:0]      grant;
  logic [IdxW-1:0]          gnt_idx;
  logic                     xfer;
  logic [TagWidth-1:0]      sel_tag;
  logic [DatapathWidth-1:0] sel_result;
  logic                     sel_br;

  logic                     cdb_valid_q, cdb_valid_d;
  logic [TagWidth-1:0]      cdb_tag_q, cdb_tag_d;
  logic [DatapathWidth-1:0] cdb_result_q, cdb_result_d;
  logic                     cdb_br_q, cdb_br_d;
  logic [IdxW-1:0]          cdb_unit_q, cdb_unit_d;

  // Round-robin search from the slot after the last winner; the data mux only
  // feeds the capture registers, so ready never depends on the data inputs.
  always_comb begin
    int              idx;
    logic [IdxW-1:0] idx_b;
    logic            found;
    grant      = '0;
    gnt_idx    = '0;
    sel_tag    = '0;
    sel_result = '0;
    sel_br     = 1'b0;
    found      = 1'b0;
    idx        = 0;
    idx_b      = '0;
    for (int i = 1; i <= NumUnits; i++) begin
      idx   = (int'(ptr_q) + i) % NumUnits;
      idx_b = IdxW'(idx);
      if (!found && fu_valid_i[idx_b]) begin
        found          = 1'b1;
        grant[idx_b]   = 1'b1;
        gnt_idx        = idx_b;
        sel_tag        = fu_tag_i[idx*TagWidth +: TagWidth];
        sel_result     = fu_result_i[idx*DatapathWidth +: DatapathWidth];
        sel_br         = fu_branch_taken_i[idx_b];
      end
    end
    if (rst_i || flush_i) begin
      grant = '0;
    end
  end

  assign xfer       = |grant;
  assign fu_ready_o = grant;

  // Pointer advances only on a transfer; data fields hold when idle.
  always_comb begin
    ptr_d        = ptr_q;
    cdb_valid_d  = xfer;
    cdb_tag_d    = cdb_tag_q;
    cdb_result_d = cdb_result_q;
    cdb_br_d     = cdb_br_q;
    cdb_unit_d   = cdb_unit_q;
    if (xfer) begin
      ptr_d        = gnt_idx;
      cdb_tag_d    = sel_tag;
      cdb_result_d = sel_result;
      cdb_br_d     = sel_br;
      cdb_unit_d   = gnt_idx;
    end
  end

  // State registers; reset pointer at NumUnits-1 so unit 0 wins first.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_q        <= IdxW'(NumUnits - 1);
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= '0;
      cdb_result_q <= '0;
      cdb_br_q     <= 1'b0;
      cdb_unit_q   <= '0;
    end else begin
      ptr_q        <= ptr_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_result_q <= cdb_result_d;
      cdb_br_q     <= cdb_br_d;
      cdb_unit_q   <= cdb_unit_d;
    end
  end

  assign cdb_valid_o        = cdb_valid_q;
  assign cdb_tag_o          = cdb_tag_q;
  assign cdb_result_o       = cdb_result_q;
  assign cdb_branch_taken_o = cdb_br_q;
  assign cdb_unit_o         = cdb_unit_q;

`ifdef CDB_ARBITER_STATS_EN
  logic [15:0] stat_bcast_q, stat_bcast_d;
  logic [15:0] stat_conf_q, stat_conf_d;
  logic        conflict;

  // More than one request bit set (x & (x-1) clears the lowest set bit).
  assign conflict = ((fu_valid_i & (fu_valid_i - NumUnits'(1))) != '0) && !flush_i;

  // Saturating counter increments.
  always_comb begin
    stat_bcast_d = stat_bcast_q;
    stat_conf_d  = stat_conf_q;
    if (cdb_valid_q && (stat_bcast_q != 16'hFFFF)) stat_bcast_d = stat_bcast_q + 16'd1;
    if (conflict && (stat_conf_q != 16'hFFFF))     stat_conf_d  = stat_conf_q + 16'd1;
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_bcast_q <= '0;
      stat_conf_q  <= '0;
    end else begin
      stat_bcast_q <= stat_bcast_d;
      stat_conf_q  <= stat_conf_d;
    end
  end

  assign stat_broadcasts_o = stat_bcast_q;
  assign stat_conflicts_o  = stat_conf_q;
`endif

endmodule
